stopwatch_button_conditioner: RTL and testbench
===============================================

Name: stopwatch_button_conditioner

Overview:
Input-conditioning stage directly upstream of the stopwatch top level. Takes the two raw, asynchronous, bouncing push-button inputs (start, stop) and produces clean single-cycle start/stop pulses for the stopwatch core. It also produces a long-press "clear" pulse from the stop button. One synchronizer + debounce FSM per button, plus output arbitration.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive stable samples required to accept a press or release (10 ms at 100 MHz); legal range ≥ 2
HOLD_CYCLES, 200000000, cycles the stop button must stay pressed after acceptance to emit clear (2 s at 100 MHz); must be > DEBOUNCE_CYCLES
BTN_ACTIVE_LOW, 0, 1 = raw buttons read 0 when pressed (inverted before synchronizer)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
btn_start_raw  input  1  raw start button, asynchronous to clk
btn_stop_raw  input  1  raw stop button, asynchronous to clk
start  output  1  one-cycle pulse: debounced start press accepted
stop  output  1  one-cycle pulse: debounced stop press accepted
clear  output  1  one-cycle pulse: stop held HOLD_CYCLES after acceptance
btn_level  output  2  debounced levels {stop, start}; 1 in PRESSED/RELEASE_WAIT

Behaviour:
- Reset: the synchronizer flops, all FSMs (IDLE), all counters and start/stop/clear/btn_level reset to 0. A reset asserted mid-operation aborts every debounce/hold in progress; no pulse is emitted during or on exit from reset.
- Polarity: if BTN_ACTIVE_LOW=1, invert the raw input ahead of the synchronizer.
- Synchronizer: 2-flop chain per button (s1 <= raw, s2 <= s1). Only s2 is used downstream.
- Per-button FSM (identical for start and stop), counter cnt of width $clog2(DEBOUNCE_CYCLES+1):
  - IDLE: s2=1 -> PRESS_WAIT with cnt=1; otherwise stay.
  - PRESS_WAIT: s2=0 -> IDLE, cnt=0 (bounce rejected, no pulse). s2=1 and cnt==DEBOUNCE_CYCLES -> PRESSED and raise the press request. Otherwise cnt++.
  - PRESSED: s2=0 -> RELEASE_WAIT with cnt=1; s2=1 -> stay.
  - RELEASE_WAIT: s2=1 -> PRESSED, cnt=0, no new press request (release bounce). s2=0 and cnt==DEBOUNCE_CYCLES -> IDLE. Otherwise cnt++.
- Latency: raw sampled high first at edge k and held high. Then the start/stop pulse is registered high for exactly one cycle beginning at edge k+DEBOUNCE_CYCLES+2.
- Outputs are registered. Each pulse is exactly one cycle wide. At most one start pulse and one stop pulse per accepted press, regardless of hold duration.
- Hold (stop button only): hold counter of width $clog2(HOLD_CYCLES+1).
  - Cleared on entry to PRESSED.
  - Increments each cycle in PRESSED; saturates.
  - Frozen (not cleared) in RELEASE_WAIT.
  - Cleared in IDLE.
  - If PRESSED was entered at edge P and the button is held with no release bounce, clear is high for one cycle beginning at edge P+HOLD_CYCLES.
  - clear fires once per accepted press. The stop pulse at P is still emitted.
- Arbitration: if start and stop press requests occur on the same edge, stop wins. The start pulse is dropped permanently for that press, while its FSM still advances to PRESSED. A start request never delays or suppresses a clear.
- Button held through reset release: treated as a fresh press. A full debounce runs and a pulse is emitted at the normal latency.
- No combinational path from any input to any output.

Test Plan:
(Bench parameters: DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, BTN_ACTIVE_LOW=0.)
- Clean press: btn_start_raw 0->1 sampled first at edge 10, held 50 cycles -> start=1 for exactly the cycle after edge 16; stop=clear=0; btn_level[0]=1 from edge 16 until release debounce completes.
- Bounce rejection: btn_stop_raw toggles 1,1,0,1,1,0 (one value per cycle), then held 0 -> no stop pulse; stop FSM returns to IDLE; btn_level=0 throughout.
- Long press: btn_stop_raw held high 40 cycles from edge 10 -> stop pulse after edge 16, clear pulse after edge 36, no second clear; releasing then re-pressing for 40 cycles -> second stop pulse and second clear.
- Simultaneous press: both raw buttons rise at edge 10 -> stop pulses after edge 16, start stays 0 for the whole press; release both, press start alone -> start pulse at normal latency.
- Release bounce: press stop until PRESSED, then raw 0,1,0 glitch followed by continuous 0 -> no extra stop pulse; IDLE reached 4+1 edges after the last rising s2 sample reverts.
- Reset mid-operation: assert rst while start is in PRESS_WAIT with cnt=3 -> no pulse, all outputs 0; button still held after rst deasserts at edge R -> start pulse after edge R+6.

Source files
------------

// File: rtl/stopwatch_button_conditioner.sv
// Conditions the raw start/stop push-buttons into clean one-cycle start/stop pulses,
// plus a long-press clear pulse from the stop button.
module stopwatch_button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_CYCLES     = 200000000,
    parameter bit BTN_ACTIVE_LOW  = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start_raw,
    input  logic       btn_stop_raw,
    output logic       start,
    output logic       stop,
    output logic       clear,
    output logic [1:0] btn_level
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(DEBOUNCE_CYCLES);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    // Index 0 is the start button, index 1 the stop button.
    logic [1:0]          raw;
    logic [1:0]          s1;
    logic [1:0]          s2;
    state_t              state      [2];
    state_t              state_next [2];
    logic [1:0][CW-1:0]  cnt;
    logic [1:0][CW-1:0]  cnt_next;
    logic [HW-1:0]       hold;
    logic [HW-1:0]       hold_next;
    logic [1:0]          press_req;
    logic [1:0]          level_next;
    logic                clear_req;

    assign raw = {btn_stop_raw, btn_start_raw} ^ {2{BTN_ACTIVE_LOW}};

    // State register: synchronizers, debounce FSMs and the stop hold counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1       <= '0;
            s2       <= '0;
            state[0] <= IDLE;
            state[1] <= IDLE;
            cnt      <= '0;
            hold     <= '0;
        end else begin
            s1       <= raw;
            s2       <= s1;
            state[0] <= state_next[0];
            state[1] <= state_next[1];
            cnt      <= cnt_next;
            hold     <= hold_next;
        end
    end

    // Next-state logic, identical for both buttons.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_next[i] = state[i];
            cnt_next[i]   = cnt[i];
            case (state[i])
                IDLE: begin
                    cnt_next[i] = '0;
                    if (s2[i]) begin
                        state_next[i] = PRESS_WAIT;
                        cnt_next[i]   = CNT_ONE;
                    end
                end
                PRESS_WAIT: begin
                    if (!s2[i]) begin
                        state_next[i] = IDLE;
                        cnt_next[i]   = '0;
                    end else if (cnt[i] == CNT_MAX) begin
                        state_next[i] = PRESSED;
                        cnt_next[i]   = '0;
                    end else begin
                        cnt_next[i] = cnt[i] + CNT_ONE;
                    end
                end
                PRESSED: begin
                    cnt_next[i] = '0;
                    if (!s2[i]) begin
                        state_next[i] = RELEASE_WAIT;
                        cnt_next[i]   = CNT_ONE;
                    end
                end
                RELEASE_WAIT: begin
                    if (s2[i]) begin
                        state_next[i] = PRESSED;
                        cnt_next[i]   = '0;
                    end else if (cnt[i] == CNT_MAX) begin
                        state_next[i] = IDLE;
                        cnt_next[i]   = '0;
                    end else begin
                        cnt_next[i] = cnt[i] + CNT_ONE;
                    end
                end
                default: begin
                    state_next[i] = IDLE;
                    cnt_next[i]   = '0;
                end
            endcase
        end

        // Hold survives release bounces so clear still fires only once per accepted press.
        hold_next = hold;
        case (state[1])
            PRESSED:      if (hold != HOLD_MAX) hold_next = hold + HOLD_ONE;
            RELEASE_WAIT: hold_next = hold;
            default:      hold_next = '0;
        endcase
    end

    // Output decode; everything below is registered before leaving the block.
    always_comb begin
        press_req  = '0;
        level_next = '0;
        for (int i = 0; i < 2; i++) begin
            press_req[i]  = (state[i] == PRESS_WAIT) && s2[i] && (cnt[i] == CNT_MAX);
            level_next[i] = (state_next[i] == PRESSED) || (state_next[i] == RELEASE_WAIT);
        end
        clear_req = (state[1] == PRESSED) && (hold == HOLD_LAST);
    end

    // Stop wins a same-edge tie; the start press is then dropped for good.
    always_ff @(posedge clk) begin
        if (rst) begin
            start     <= 1'b0;
            stop      <= 1'b0;
            clear     <= 1'b0;
            btn_level <= '0;
        end else begin
            start     <= press_req[0] && !press_req[1];
            stop      <= press_req[1];
            clear     <= clear_req;
            btn_level <= level_next;
        end
    end
endmodule

// File: tb/tb_stopwatch_button_conditioner.sv
// Randomized and directed bench for stopwatch_button_conditioner against a
// run-length reference model of the debounce/hold rules.
module tb_stopwatch_button_conditioner;
    localparam int D = 4;
    localparam int H = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_start_raw;
    logic       btn_stop_raw;
    logic       start;
    logic       stop;
    logic       clear;
    logic [1:0] btn_level;

    always #5 clk = ~clk;

    stopwatch_button_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .HOLD_CYCLES    (H),
        .BTN_ACTIVE_LOW (1'b0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_start_raw(btn_start_raw),
        .btn_stop_raw (btn_stop_raw),
        .start        (start),
        .stop         (stop),
        .clear        (clear),
        .btn_level    (btn_level)
    );

    // Expected {start, stop, clear, btn_level} after each clock edge.
    logic [4:0] exp_q[$];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: a debounced level flips after D+1 consecutive disagreeing
    // samples of the synchronized input; hold counts cycles spent stably pressed.
    logic [1:0] m_s1, m_s2, m_lvl;
    int         m_run[2];
    int         m_hold;

    task automatic model_step(input logic r, input logic a, input logic b);
        logic [1:0] press;
        logic       clr;
        logic       in_pressed;
        logic       old_lvl1;
        press = '0;
        clr   = 1'b0;
        if (r) begin
            m_s1     = '0;
            m_s2     = '0;
            m_lvl    = '0;
            m_run[0] = 0;
            m_run[1] = 0;
            m_hold   = 0;
        end else begin
            old_lvl1   = m_lvl[1];
            in_pressed = m_lvl[1] && (m_run[1] == 0);
            for (int i = 0; i < 2; i++) begin
                if (m_s2[i] != m_lvl[i]) m_run[i]++;
                else m_run[i] = 0;
                if (m_run[i] == D + 1) begin
                    m_lvl[i] = m_s2[i];
                    m_run[i] = 0;
                    press[i] = m_s2[i];
                end
            end
            if (!old_lvl1) begin
                m_hold = 0;
            end else if (in_pressed && m_hold < H) begin
                m_hold++;
                if (m_hold == H) clr = 1'b1;
            end
            m_s2 = m_s1;
            m_s1 = {b, a};
        end
        exp_q.push_back({press[0] & ~press[1], press[1], clr, m_lvl});
    endtask

    task automatic drive(input logic r, input logic a, input logic b);
        rst           = r;
        btn_start_raw = a;
        btn_stop_raw  = b;
        model_step(r, a, b);
        @(negedge clk);
    endtask

    task automatic drive_n(input logic r, input logic a, input logic b, input int n);
        for (int k = 0; k < n; k++) drive(r, a, b);
    endtask

    // Monitor: one observation per edge, compared against the queued expectation.
    initial begin
        logic [4:0] got;
        logic [4:0] exp;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                got = {start, stop, clear, btn_level};
                total++;
                if (got !== exp) begin
                    bad++;
                    $display("FAIL outputs cycle=%0d got{start,stop,clear,lvl}=%b exp=%b", cyc, got, exp);
                end
            end
            cyc++;
        end
    end

    initial begin
        drive_n(1, 0, 0, 3);

        // Clean start press and release.
        drive_n(0, 0, 0, 7);
        drive_n(0, 1, 0, 50);
        drive_n(0, 0, 0, 12);

        // Stop bounce 1,1,0,1,1,0 then low.
        drive(0, 0, 1); drive(0, 0, 1); drive(0, 0, 0);
        drive(0, 0, 1); drive(0, 0, 1); drive(0, 0, 0);
        drive_n(0, 0, 0, 12);

        // Acceptance threshold: D samples rejected, D+1 accepted.
        drive_n(0, 0, 1, D);
        drive_n(0, 0, 0, 12);
        drive_n(0, 0, 1, D + 1);
        drive_n(0, 0, 0, 12);

        // Long press twice: stop plus clear each time, never a second clear.
        drive_n(0, 0, 1, 40);
        drive_n(0, 0, 0, 12);
        drive_n(0, 0, 1, 40);
        drive_n(0, 0, 0, 12);

        // Simultaneous press: stop wins; then start alone.
        drive_n(0, 1, 1, 20);
        drive_n(0, 0, 0, 12);
        drive_n(0, 1, 0, 15);
        drive_n(0, 0, 0, 12);

        // Release bounce on stop.
        drive_n(0, 0, 1, 12);
        drive(0, 0, 0); drive(0, 0, 1); drive(0, 0, 0);
        drive_n(0, 0, 0, 14);

        // Reset while start is mid-debounce, button held through reset release.
        drive_n(0, 1, 0, 5);
        drive_n(1, 1, 0, 2);
        drive_n(0, 1, 0, 15);
        drive_n(0, 0, 0, 12);

        // Random segments mixing bounces, long holds and occasional resets.
        for (int seg = 0; seg < 300; seg++) begin
            int   mode;
            int   len;
            logic a;
            logic b;
            mode = $urandom_range(0, 19);
            a    = 1'($urandom_range(0, 1));
            b    = 1'($urandom_range(0, 1));
            if (mode == 0) begin
                drive_n(1, a, b, $urandom_range(1, 3));
            end else begin
                len = ($urandom_range(0, 1) == 0) ? $urandom_range(1, D + 2) : $urandom_range(1, 30);
                drive_n(0, a, b, len);
            end
        end
        drive_n(0, 0, 0, 20);

        // Every queued expectation must have been consumed by the monitor.
        repeat (3) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain leftover=%0d required=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
